// File: rtl/sort_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | sort_pkg : shared types and helpers for the nth-rank sort interface  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package sort_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_EMIT  = 2'd3
    } state_t;

    localparam int c_max_num_size_def = 32;
    localparam int c_mult_w           = 3;

    // The engine's 2-bit count field cannot represent 4, so 0 stands for 4.
    function automatic logic [c_mult_w-1:0] decode_count(input logic [1:0] cnt);
        return (cnt == 2'd0) ? 3'd4 : {1'b0, cnt};
    endfunction

endpackage
`default_nettype wire

// File: rtl/nth_rank_requester.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | nth_rank_requester : queries a 4-way rank engine and streams the     |
// |                      distinct frame values in ascending order.       |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module nth_rank_requester
    import sort_pkg::*;
#(
    parameter int MAX_NUM_SIZE   = c_max_num_size_def,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    input  logic [3:0][MAX_NUM_SIZE-1:0] frame_in,
    input  logic                         frame_valid_in,
    output logic                         frame_ready_out,
    output logic [3:0][MAX_NUM_SIZE-1:0] srt_numbers_out,
    output logic [1:0]                   srt_index_out,
    output logic                         srt_valid_out,
    input  logic                         srt_busy_in,
    input  logic [MAX_NUM_SIZE-1:0]      srt_result_in,
    input  logic [1:0]                   srt_count_in,
    input  logic                         srt_valid_in,
    output logic [MAX_NUM_SIZE-1:0]      val_out,
    output logic [c_mult_w-1:0]          mult_out,
    output logic                         last_out,
    output logic                         val_valid_out,
    input  logic                         val_ready_in,
    output logic                         error_out
);

    localparam int                 c_cnt_w    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

    state_t                         r_state;
    logic [1:0]                     r_idx;
    logic [c_cnt_w-1:0]             r_cnt;
    logic [3:0][MAX_NUM_SIZE-1:0]   r_numbers;
    logic                           r_srt_valid;
    logic [MAX_NUM_SIZE-1:0]        r_val;
    logic [c_mult_w-1:0]            r_mult;
    logic                           r_last;
    logic                           r_val_valid;
    logic                           r_frame_ready;
    logic                           r_error;

    logic [c_mult_w-1:0]            w_mult_dec;
    logic [c_mult_w-1:0]            w_idx_sum;

    assign w_mult_dec = decode_count(srt_count_in);
    // 3-bit sum cannot wrap (max 3+4); anything reaching 4 ends the frame.
    assign w_idx_sum  = {1'b0, r_idx} + w_mult_dec;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_state       <= S_IDLE;
            r_idx         <= 2'd0;
            r_cnt         <= '0;
            r_numbers     <= '0;
            r_srt_valid   <= 1'b0;
            r_val         <= '0;
            r_mult        <= '0;
            r_last        <= 1'b0;
            r_val_valid   <= 1'b0;
            r_frame_ready <= 1'b1;
            r_error       <= 1'b0;
        end else begin
            r_srt_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (frame_valid_in) begin
                        r_numbers     <= frame_in;
                        r_idx         <= 2'd0;
                        r_error       <= 1'b0;
                        r_frame_ready <= 1'b0;
                        r_state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!srt_busy_in) begin
                        r_srt_valid <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (srt_valid_in) begin
                        r_val       <= srt_result_in;
                        r_mult      <= w_mult_dec;
                        r_last      <= (w_idx_sum >= 3'd4);
                        r_val_valid <= 1'b1;
                        r_state     <= S_EMIT;
                    end else if (r_cnt == c_cnt_last) begin
                        r_error       <= 1'b1;
                        r_frame_ready <= 1'b1;
                        r_state       <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_EMIT: begin
                    if (val_ready_in) begin
                        r_val_valid <= 1'b0;
                        if (r_last) begin
                            r_frame_ready <= 1'b1;
                            r_state       <= S_IDLE;
                        end else begin
                            // Skip every copy of the value just emitted.
                            r_idx   <= r_idx + r_mult[1:0];
                            r_state <= S_ISSUE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign frame_ready_out = r_frame_ready;
    assign srt_numbers_out = r_numbers;
    assign srt_index_out   = r_idx;
    assign srt_valid_out   = r_srt_valid;
    assign val_out         = r_val;
    assign mult_out        = r_mult;
    assign last_out        = r_last;
    assign val_valid_out   = r_val_valid;
    assign error_out       = r_error;

endmodule
`default_nettype wire

// File: doc/nth_rank_requester.md
# nth_rank_requester

Initiator for the 4-way nth-smallest sort engine. Accepts a frame of four candidate values (e.g. per-pair collision times), issues rank queries to the engine, and streams the distinct values of the frame in ascending order with their multiplicity. Sits between the physics candidate generator and the event scheduler; the sort engine is instantiated alongside it by the parent.

## Interface
- MAX_NUM_SIZE, 32, width of each value
- TIMEOUT_CYCLES, 16, max cycles to wait for an engine response
- clk_in  in  1  system clock
- rst_n_in  in  1  reset; one clock; reset is synchronous and active-low
- frame_in  in  [3:0][MAX_NUM_SIZE-1:0]  four candidate values
- frame_valid_in  in  1  frame offered
- frame_ready_out  out  1  high only in IDLE
- srt_numbers_out  out  [3:0][MAX_NUM_SIZE-1:0]  values to engine (registered frame copy)
- srt_index_out  out  2  rank queried
- srt_valid_out  out  1  one-cycle request pulse
- srt_busy_in  in  1  engine busy
- srt_result_in  in  MAX_NUM_SIZE  nth smallest value
- srt_count_in  in  2  occurrences of that value in the frame; 0 encodes 4
- srt_valid_in  in  1  response strobe
- val_out  out  MAX_NUM_SIZE  emitted value
- mult_out  out  3  multiplicity, 1..4
- last_out  out  1  final value of frame
- val_valid_out  out  1  emission valid
- val_ready_in  in  1  downstream accepts
- error_out  out  1  sticky timeout flag

## Operation
- States: IDLE, ISSUE, WAIT, EMIT.
- IDLE: frame_ready_out=1. On frame_valid_in: latch frame into srt_numbers_out, idx<=0, error_out<=0, go ISSUE.
- ISSUE: if srt_busy_in=0, pulse srt_valid_out with srt_index_out=idx[1:0], clear timeout counter, go WAIT; else stay, no pulse.
- WAIT: on srt_valid_in, capture result -> val_out, mult = (srt_count_in==0) ? 4 : srt_count_in, go EMIT. Counter increments every WAIT cycle; on reaching TIMEOUT_CYCLES-1 with no response: error_out<=1, go IDLE, no emission.
- EMIT: val_valid_out=1; val_out/mult_out/last_out held stable until val_ready_in. last_out = (idx + mult >= 4), 3-bit sum, no wrap. On handshake: if last, go IDLE; else idx<=idx+mult, go ISSUE.
- Duplicates skipped: next query jumps past all copies, so each distinct value is emitted once.
- srt_numbers_out and srt_index_out stable from request pulse through response (engine samples them after the pulse).
- srt_valid_in outside WAIT ignored (late/stray responses).
- Response with idx+mult > 4 (inconsistent engine): treated as last; no error.

## Timing
- Reset values: frame_ready_out=1 (IDLE), srt_valid_out=0, srt_index_out=0, srt_numbers_out=0, val_out=0, mult_out=0, last_out=0, val_valid_out=0, error_out=0.
- Frame accepted cycle N -> srt_valid_out at N+1 (if engine idle).
- srt_valid_in at cycle M -> val_valid_out at M+1.
- EMIT handshake at cycle K -> next srt_valid_out at K+1 (if engine idle); frame_ready_out at K+1 if last.
- Reset mid-operation: all registers to reset values next edge; in-flight engine response ignored.
- Timeout: error_out rises TIMEOUT_CYCLES cycles after the request pulse, same cycle as return to IDLE.

## Structure
- Shared package sort_pkg: state enum, MAX_NUM_SIZE default, mult width constant (3), count-zero-means-four decode function.
- No sub-module; the timeout counter stays inline. The sort engine is a sibling, not a child.

## Test plan
- Frame {9,3,7,5}, behavioural engine model -> queries idx 0,1,2,3; emits 3,5,7,9 each mult 1; last_out only with 9.
- Frame {4,4,2,4} -> queries idx 0,1 only; emits 2 mult 1, then 4 mult 3 last.
- Frame {6,6,6,6}, engine count=0 -> single query; emits 6 mult 4 last.
- srt_busy_in high 3 cycles in ISSUE -> no pulse until busy low; val_ready_in low 5 cycles in EMIT -> outputs held, no new query.
- Engine silent -> error_out=1 exactly 16 cycles after pulse, frame_ready_out=1; next frame accept clears error_out.
- rst_n_in low 1 cycle during WAIT, then stray srt_valid_in -> no val_valid_out, all outputs at reset values.
